// File: rtl/rom_arb_pkg.sv
// Shared types and helpers for the ROM burst arbiter and any other
// round-robin arbiters in this block.
package rom_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        READ = 1'b1
    } arb_state_t;

    // Widest requester vector the generic grant helper can handle.
    localparam int unsigned MAX_REQ   = 32;
    localparam int unsigned MAX_IDX_W = 5;

    // One-hot round-robin grant: first set bit of valid[n-1:0] searching
    // upward from ptr+1 and wrapping at n. Returns all-zero when nothing
    // is valid. Bits at and above n are always zero.
    function automatic logic [MAX_REQ-1:0] next_rr(
        input int unsigned        n,
        input int unsigned        ptr,
        input logic [MAX_REQ-1:0] valid
    );
        logic [MAX_REQ-1:0] gnt;
        logic               found;
        int unsigned        idx;
        gnt   = '0;
        found = 1'b0;
        idx   = 0;
        for (int unsigned k = 1; k <= MAX_REQ; k++) begin
            if (k <= n) begin
                idx = (ptr + k) % n;
                if (!found && valid[idx[MAX_IDX_W-1:0]]) begin
                    gnt[idx[MAX_IDX_W-1:0]] = 1'b1;
                    found = 1'b1;
                end
            end
        end
        return gnt;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first valid
// requester after ptr, wrapping. Holds no state; the owner keeps ptr.
module rr_arbiter
    import rom_arb_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]          valid,
    input  logic [$clog2(N)-1:0]  ptr,
    output logic [N-1:0]          grant
);

    // Widen into the generic helper and keep only the N live grant bits.
    always_comb begin
        grant = N'(next_rr(N, 32'(ptr), MAX_REQ'(valid)));
    end

endmodule

// File: rtl/rom_burst_arbiter.sv
// Round-robin arbiter sharing one combinational ROM among NUM_REQ
// requesters. Each grant reads len+1 sequential addresses and returns them
// on a single registered valid/ready response channel tagged with the id.
module rom_burst_arbiter
    import rom_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 3,
    parameter int DATA_W  = 8,
    parameter int LEN_W   = 3
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ*LEN_W-1:0]    req_len,
    output logic [ADDR_W-1:0]           rom_addr,
    input  logic [DATA_W-1:0]           rom_dout,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [DATA_W-1:0]           rsp_data,
    output logic [$clog2(NUM_REQ)-1:0]  rsp_id,
    output logic                        rsp_last,
    output logic                        busy
);

    localparam int ID_W = $clog2(NUM_REQ);

    arb_state_t          state;
    arb_state_t          state_next;

    logic [ID_W-1:0]     rr_ptr;
    logic [NUM_REQ-1:0]  grant;
    logic [ID_W-1:0]     gnt_idx;
    logic [ADDR_W-1:0]   sel_addr;
    logic [LEN_W-1:0]    sel_len;

    logic [ADDR_W-1:0]   cur_addr;
    logic [ADDR_W-1:0]   addr_hold;
    logic [LEN_W-1:0]    cur_len;
    logic [LEN_W-1:0]    beat_cnt;
    logic [ID_W-1:0]     cur_id;

    logic                accept;
    logic                load;
    logic                last_beat;

    rr_arbiter #(
        .N (NUM_REQ)
    ) u_rr (
        .valid (req_valid),
        .ptr   (rr_ptr),
        .grant (grant)
    );

    // Decode the one-hot grant into an index and pick that requester's fields.
    always_comb begin
        gnt_idx  = '0;
        sel_addr = '0;
        sel_len  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                gnt_idx  = ID_W'(i);
                sel_addr = req_addr[i*ADDR_W +: ADDR_W];
                sel_len  = req_len[i*LEN_W +: LEN_W];
            end
        end
    end

    // Grants are only offered in IDLE; gated by rst_n so nothing is offered
    // while reset is held.
    assign req_ready = (state == IDLE && rst_n) ? grant : '0;
    assign last_beat = (beat_cnt == cur_len);
    // The ROM bus follows the burst while reading and otherwise parks on the
    // last address actually read.
    assign rom_addr  = (state == READ) ? cur_addr : addr_hold;
    assign busy      = (state != IDLE) || rsp_valid;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state: accept a grant in IDLE; in READ step one beat whenever the
    // response register is empty or being drained this cycle.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        load       = 1'b0;
        case (state)
            IDLE: begin
                if (|grant) begin
                    accept     = 1'b1;
                    state_next = READ;
                end
            end
            READ: begin
                if (!rsp_valid || rsp_ready) begin
                    load = 1'b1;
                    if (last_beat) begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Burst context: captured on grant, advanced once per loaded beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr    <= ID_W'(NUM_REQ - 1);
            cur_addr  <= '0;
            addr_hold <= '0;
            cur_len   <= '0;
            beat_cnt  <= '0;
            cur_id    <= '0;
        end else if (accept) begin
            rr_ptr   <= gnt_idx;
            cur_addr <= sel_addr;
            cur_len  <= sel_len;
            cur_id   <= gnt_idx;
            beat_cnt <= '0;
        end else if (load) begin
            addr_hold <= cur_addr;
            cur_addr  <= cur_addr + 1'b1;
            beat_cnt  <= beat_cnt + 1'b1;
        end
    end

    // Response register: a new beat overwrites a drained one in the same
    // cycle, so valid only drops when nothing new is loaded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_id    <= '0;
            rsp_last  <= 1'b0;
        end else if (load) begin
            rsp_valid <= 1'b1;
            rsp_data  <= rom_dout;
            rsp_id    <= cur_id;
            rsp_last  <= last_beat;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule
